// File: rtl/sdu_rx_pack.sv
// sdu_rx_pack: receive-path packer for averaged playback samples.
//   Normalises each 32-bit averaged sample by the average count (arithmetic
//   shift), reduces it to 16 bits and packs sample pairs into 32-bit words.
//   Each burst (contiguous strobes) is framed as
//   header {A55A, seq_num} / data words / trailer {5AA5, sample_count}
//   inside a first-word-fall-through FIFO.
//
// Build option: define SDU_RX_PACK_SAT_EN to saturate the shifted sample to
//   [-32768, 32767]; otherwise the low 16 bits are kept (wrap).
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   in_data, in_strobe   averaged sample and its valid (no backpressure)
//   ave_shift            log2 of averages, stable during a frame
//   clear_status         clears overflow / proto_err (a same-cycle set wins)
//   out_data, out_valid  FIFO head word, consumed on out_valid & out_ready
//   out_ready
//   overflow             sticky: a word was dropped on a full FIFO
//   proto_err            sticky: a sample arrived during the trailer window
//   seq_num              completed frame count
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for the first strobe of a frame
// STREAM  | header + data words; pend_q marks a 1-sample frame's pad
// TRAILER | trailer word written, seq_num advances, strobes are dropped
module sdu_rx_pack #(
   parameter int FIFO_AW = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in_data,
   input  logic        in_strobe,
   input  logic [3:0]  ave_shift,
   input  logic        clear_status,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overflow,
   output logic        proto_err,
   output logic [15:0] seq_num
);

   typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_TRAILER} state_t;

   state_t            state_q, state_d;
   logic              s1_valid_q, s1_valid_d;
   logic [15:0]       s1_data_q, s1_data_d;
   logic              first_q, first_d;
   logic              pend_q, pend_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [15:0]       pack_q, pack_d;
   logic [15:0]       seq_q, seq_d;
   logic              ovf_q, ovf_d;
   logic              perr_q, perr_d;
   logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0]       mem [2**FIFO_AW];

   logic              wr_req;
   logic [31:0]       wr_word;
   logic              drop_win;
   logic              fifo_empty, fifo_full, rd_fire, wr_fire;

   // Stage-1 reduction
`ifdef SDU_RX_PACK_SAT_EN
   logic signed [31:0] shifted;
   assign shifted = $signed(in_data) >>> ave_shift;
   always_comb begin
      s1_data_d = shifted[15:0];
      if (shifted > 32'sd32767)
         s1_data_d = 16'h7FFF;
      else if (shifted < -32'sd32768)
         s1_data_d = 16'h8000;
   end
`else
   always_comb begin
      s1_data_d = 16'($signed(in_data) >>> ave_shift);
   end
`endif

   // Strobes landing while the trailer (or a 1-sample pad) is being written
   // cannot belong to any frame and are discarded.
   assign drop_win   = (state_q == ST_TRAILER) || ((state_q == ST_STREAM) && pend_q);
   assign s1_valid_d = in_strobe && !drop_win;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pack_d  = pack_q;
      first_d = first_q;
      pend_d  = pend_q;
      seq_d   = seq_q;
      wr_req  = 1'b0;
      wr_word = '0;
      case (state_q)
         ST_IDLE: begin
            if (in_strobe) begin
               state_d = ST_STREAM;
               cnt_d   = '0;
               first_d = 1'b1;
               pend_d  = 1'b0;
            end
         end
         ST_STREAM: begin
            first_d = 1'b0;
            if (pend_q) begin
               wr_req  = 1'b1;
               wr_word = {16'h0000, pack_q};
               pend_d  = 1'b0;
               state_d = ST_TRAILER;
            end else begin
               if (s1_valid_q) begin
                  cnt_d = cnt_q + 16'd1;
                  if (!cnt_q[0]) begin
                     pack_d = s1_data_q;
                  end else begin
                     wr_req  = 1'b1;
                     wr_word = {s1_data_q, pack_q};
                  end
                  if (!in_strobe) begin
                     if (cnt_q[0]) begin
                        state_d = ST_TRAILER;
                     end else if (first_q) begin
                        // 1-sample frame: header owns this cycle, pad next
                        pend_d = 1'b1;
                     end else begin
                        wr_req  = 1'b1;
                        wr_word = {16'h0000, s1_data_q};
                        state_d = ST_TRAILER;
                     end
                  end
               end else begin
                  state_d = ST_TRAILER;
               end
               if (first_q) begin
                  wr_req  = 1'b1;
                  wr_word = {16'hA55A, seq_q};
               end
            end
         end
         ST_TRAILER: begin
            wr_req  = 1'b1;
            wr_word = {16'h5AA5, cnt_q};
            seq_d   = seq_q + 16'd1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FIFO control; a read in the same cycle frees the slot for a full write
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign rd_fire    = !fifo_empty && out_ready;
   assign wr_fire    = wr_req && (!fifo_full || rd_fire);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      ovf_d  = (wr_req && fifo_full && !rd_fire) || (ovf_q && !clear_status);
      perr_d = (in_strobe && drop_win) || (perr_q && !clear_status);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         first_q    <= 1'b0;
         pend_q     <= 1'b0;
         cnt_q      <= '0;
         pack_q     <= '0;
         seq_q      <= '0;
         ovf_q      <= 1'b0;
         perr_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         first_q    <= first_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         pack_q     <= pack_d;
         seq_q      <= seq_d;
         ovf_q      <= ovf_d;
         perr_q     <= perr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_word;
   end

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_empty ? 32'h0 : mem[rd_ptr_q[FIFO_AW-1:0]];
   assign overflow  = ovf_q;
   assign proto_err = perr_q;
   assign seq_num   = seq_q;

endmodule
